// File: rtl/debug_latch_streamer.sv
// debug_latch_streamer: snapshot NUM_CH latch words, stream masked channels as a byte frame
// Ports:
//    clk, rst          clock, synchronous active-high reset
//    ch_data, ch_mask  flattened channel words and enable mask, captured on accepted snap
//    snap              snapshot/stream request
//    tx_byte, tx_valid, tx_ready   byte stream handshake towards the UART transmitter
//    busy, done, overrun           frame in progress, end-of-frame pulse, sticky snap-while-busy
// Frame: HDR_BYTE, popcount(mask), enabled words LSB byte first, optional XOR checksum.
// Optional checksum byte enabled by macro DEBUG_LATCH_STREAMER_CSUM_EN.
module debug_latch_streamer #(
   parameter int         NUM_CH   = 16,
   parameter int         DATA_W   = 32,
   parameter logic [7:0] HDR_BYTE = 8'hA5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH-1:0]        ch_mask,
   input  logic                     snap,
   output logic [7:0]               tx_byte,
   output logic                     tx_valid,
   input  logic                     tx_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     overrun
);
   localparam int NB = DATA_W / 8;
   localparam int PW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int BW = NB > 1 ? $clog2(NB) : 1;
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
   typedef enum logic [2:0] {IDLE, HDR, CNT, DATA, CSUM, FIN} state_t;
   localparam state_t POST = CSUM;
   logic [7:0] csum_q;
`else
   typedef enum logic [2:0] {IDLE, HDR, CNT, DATA, FIN} state_t;
   localparam state_t POST = FIN;
`endif
   state_t                   state_q, state_d;
   logic [NUM_CH*DATA_W-1:0] buf_q;
   logic [NUM_CH-1:0]        mask_q;
   logic [PW-1:0]            ptr_q, ptr_d, cur;
   logic [BW-1:0]            byte_q, byte_d;
   logic [DATA_W-1:0]        word;
   logic [7:0]               cnt;
   logic                     overrun_q, found, more, cap;
   assign busy    = state_q != IDLE && state_q != FIN;
   assign done    = state_q == FIN;
   assign overrun = overrun_q;
   assign cap     = snap && (state_q == IDLE || state_q == FIN);
   assign word    = buf_q[cur*DATA_W +: DATA_W];
   // cur is the first enabled channel at or after ptr_q, so masked-off channels cost no cycles;
   // more says whether another enabled channel follows cur.
   always_comb begin
      cnt   = '0;
      cur   = '0;
      found = 1'b0;
      more  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt = cnt + 8'(mask_q[i]);
         if (mask_q[i] && PW'(i) >= ptr_q) begin
            if (found) more = 1'b1;
            else begin
               cur   = PW'(i);
               found = 1'b1;
            end
         end
      end
   end
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      byte_d   = byte_q;
      tx_valid = 1'b0;
      tx_byte  = '0;
      case (state_q)
         IDLE: state_d = cap ? HDR : IDLE;
         HDR: begin
            tx_valid = 1'b1;
            tx_byte  = HDR_BYTE;
            if (tx_ready) state_d = CNT;
         end
         CNT: begin
            tx_valid = 1'b1;
            tx_byte  = cnt;
            if (tx_ready) begin
               ptr_d   = '0;
               byte_d  = '0;
               state_d = cnt != 8'd0 ? DATA : POST;
            end
         end
         DATA: begin
            tx_valid = 1'b1;
            tx_byte  = word[byte_q*8 +: 8];
            if (tx_ready) begin
               if (byte_q == BW'(NB - 1)) begin
                  byte_d  = '0;
                  ptr_d   = cur + 1'b1;
                  state_d = more ? DATA : POST;
               end else byte_d = byte_q + 1'b1;
            end
         end
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
         CSUM: begin
            tx_valid = 1'b1;
            tx_byte  = csum_q;
            if (tx_ready) state_d = FIN;
         end
`endif
         FIN: state_d = cap ? HDR : IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         buf_q     <= '0;
         mask_q    <= '0;
         ptr_q     <= '0;
         byte_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         byte_q  <= byte_d;
         if (cap) begin
            buf_q  <= ch_data;
            mask_q <= ch_mask;
         end
         if (snap && busy) overrun_q <= 1'b1;
      end
   end
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
   always_ff @(posedge clk) begin
      if (rst || cap) csum_q <= '0;
      else if (tx_valid && tx_ready) csum_q <= csum_q ^ tx_byte;
   end
`endif
endmodule

// File: tb/tb_debug_latch_streamer.sv
// tb_debug_latch_streamer: directed frame checks for debug_latch_streamer with 4 channels of 32 bits
module tb_debug_latch_streamer;
   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] ch_data = '0;
   logic [3:0]   ch_mask = '0;
   logic         snap = 1'b0;
   logic         tx_ready = 1'b1;
   logic [7:0]   tx_byte;
   logic         tx_valid, busy, done, overrun;
   int           cmp = 0, errs = 0;
   logic [7:0]   got[$];
   int           done_c, busy_c, unstable, stalls;

   debug_latch_streamer #(.NUM_CH(4), .DATA_W(32), .HDR_BYTE(8'hA5)) dut (
      .clk(clk), .rst(rst), .ch_data(ch_data), .ch_mask(ch_mask), .snap(snap),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic pulse_snap();
      @(negedge clk);
      snap = 1'b1;
      @(posedge clk);
      #1 snap = 1'b0;
   endtask

   // Observes one frame cycle by cycle starting just after the capturing edge.
   task automatic run_frame(input int maxc, input logic [15:0] pat, input int dsnap_c,
                            input logic fin_snap, input logic [31:0] alt);
      logic       hold = 1'b0;
      logic [7:0] hb = '0;
      got.delete();
      done_c = -1; busy_c = 0; unstable = 0; stalls = 0;
      for (int c = 1; c <= maxc; c++) begin
         @(negedge clk);
         snap = 1'b0;
         tx_ready = pat[c % 16];
         if (hold) begin
            stalls++;
            if (!tx_valid || tx_byte !== hb) unstable++;
         end
         hold = tx_valid && !tx_ready;
         hb = tx_byte;
         if (busy) busy_c++;
         if (tx_valid && tx_ready) got.push_back(tx_byte);
         if (c == dsnap_c) begin
            snap = 1'b1;
            ch_data[31:0] = alt;
         end
         if (done) begin
            done_c = c;
            if (fin_snap) begin
               snap = 1'b1;
               @(posedge clk);
               #1 snap = 1'b0;
            end
            break;
         end
      end
      tx_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      cmp++; if (tx_byte !== 8'h00) begin errs++; $display("FAIL reset_tx_byte: got %h want 00", tx_byte); end
      cmp++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
      cmp++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
      cmp++; if (overrun !== 1'b0) begin errs++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic [7:0] exp[$];
      exp = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
      exp.push_back(8'hE0);
`endif
      ch_data = {32'h0, 32'h0, 32'h0, 32'h11223344};
      ch_mask = 4'b0001;
      pulse_snap();
      run_frame(30, 16'hFFFF, 0, 1'b0, 32'h0);
      cmp++; if (got.size() !== exp.size()) begin errs++; $display("FAIL single_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         cmp++; if (i >= got.size() || got[i] !== exp[i]) begin errs++; $display("FAIL single_byte%0d: got %h want %h", i, i < got.size() ? got[i] : 8'h00, exp[i]); end
      end
      cmp++; if (done_c !== exp.size() + 1) begin errs++; $display("FAIL single_done_cycle: got %0d want %0d", done_c, exp.size() + 1); end
   endtask

   task automatic test_skip();
      logic [7:0] exp[$];
      exp = '{8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
      exp.push_back(8'h84);
`endif
      ch_data = {32'h00000001, 32'h55555555, 32'hDEADBEEF, 32'h99999999};
      ch_mask = 4'b1010;
      pulse_snap();
      run_frame(30, 16'hFFFF, 0, 1'b0, 32'h0);
      cmp++; if (got.size() !== exp.size()) begin errs++; $display("FAIL skip_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         cmp++; if (i >= got.size() || got[i] !== exp[i]) begin errs++; $display("FAIL skip_byte%0d: got %h want %h", i, i < got.size() ? got[i] : 8'h00, exp[i]); end
      end
      cmp++; if (done_c !== exp.size() + 1) begin errs++; $display("FAIL skip_done_cycle: got %0d want %0d", done_c, exp.size() + 1); end
   endtask

   task automatic test_empty();
      logic [7:0] exp[$];
      exp = '{8'hA5, 8'h00};
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
      exp.push_back(8'hA5);
`endif
      ch_mask = 4'b0000;
      pulse_snap();
      run_frame(20, 16'hFFFF, 0, 1'b0, 32'h0);
      cmp++; if (got.size() !== exp.size()) begin errs++; $display("FAIL empty_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         cmp++; if (i >= got.size() || got[i] !== exp[i]) begin errs++; $display("FAIL empty_byte%0d: got %h want %h", i, i < got.size() ? got[i] : 8'h00, exp[i]); end
      end
      cmp++; if (busy_c !== exp.size()) begin errs++; $display("FAIL empty_busy_cycles: got %0d want %0d", busy_c, exp.size()); end
      cmp++; if (done_c !== exp.size() + 1) begin errs++; $display("FAIL empty_done_cycle: got %0d want %0d", done_c, exp.size() + 1); end
   endtask

   task automatic test_stall();
      logic [7:0] exp[$];
      exp = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
      exp.push_back(8'hE0);
`endif
      ch_data = {32'h0, 32'h0, 32'h0, 32'h11223344};
      ch_mask = 4'b0001;
      pulse_snap();
      run_frame(60, 16'hA659, 0, 1'b0, 32'h0);
      cmp++; if (got.size() !== exp.size()) begin errs++; $display("FAIL stall_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         cmp++; if (i >= got.size() || got[i] !== exp[i]) begin errs++; $display("FAIL stall_byte%0d: got %h want %h", i, i < got.size() ? got[i] : 8'h00, exp[i]); end
      end
      cmp++; if (unstable !== 0) begin errs++; $display("FAIL stall_stability: got %0d unstable cycles want 0", unstable); end
      cmp++; if (stalls < 3) begin errs++; $display("FAIL stall_exercised: got %0d stalled cycles want >=3", stalls); end
      cmp++; if (done_c === -1) begin errs++; $display("FAIL stall_done: got no done want done within 60 cycles"); end
   endtask

   task automatic test_overrun();
      logic [7:0] exp1[$], exp2[$];
      exp1 = '{8'hA5, 8'h01, 8'h44, 8'h33, 8'h22, 8'h11};
      exp2 = '{8'hA5, 8'h01, 8'hBE, 8'hBA, 8'hFE, 8'hCA};
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
      exp1.push_back(8'hE0);
      exp2.push_back(8'h94);
`endif
      ch_data = {32'h0, 32'h0, 32'h0, 32'h11223344};
      ch_mask = 4'b0001;
      pulse_snap();
      run_frame(30, 16'hFFFF, 4, 1'b1, 32'hCAFEBABE);
      cmp++; if (got.size() !== exp1.size()) begin errs++; $display("FAIL ovr_len1: got %0d want %0d", got.size(), exp1.size()); end
      for (int i = 0; i < exp1.size(); i++) begin
         cmp++; if (i >= got.size() || got[i] !== exp1[i]) begin errs++; $display("FAIL ovr_byte%0d: got %h want %h", i, i < got.size() ? got[i] : 8'h00, exp1[i]); end
      end
      cmp++; if (done_c !== exp1.size() + 1) begin errs++; $display("FAIL ovr_done_cycle: got %0d want %0d", done_c, exp1.size() + 1); end
      cmp++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      run_frame(30, 16'hFFFF, 0, 1'b0, 32'h0);
      cmp++; if (got.size() !== exp2.size()) begin errs++; $display("FAIL fin_len2: got %0d want %0d", got.size(), exp2.size()); end
      for (int i = 0; i < exp2.size(); i++) begin
         cmp++; if (i >= got.size() || got[i] !== exp2[i]) begin errs++; $display("FAIL fin_byte%0d: got %h want %h", i, i < got.size() ? got[i] : 8'h00, exp2[i]); end
      end
      cmp++; if (overrun !== 1'b1) begin errs++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] exp[$];
      int         bad = 0;
      exp = '{8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h01, 8'h00, 8'h00, 8'h00};
`ifdef DEBUG_LATCH_STREAMER_CSUM_EN
      exp.push_back(8'h84);
`endif
      ch_data = {32'h0, 32'h0, 32'h0, 32'h11223344};
      ch_mask = 4'b0001;
      pulse_snap();
      repeat (5) @(negedge clk);
      cmp++; if (tx_byte !== 8'h22) begin errs++; $display("FAIL mid_byte3: got %h want 22", tx_byte); end
      rst = 1'b1;
      @(negedge clk);
      cmp++; if (tx_valid !== 1'b0) begin errs++; $display("FAIL mid_rst_valid: got %b want 0", tx_valid); end
      cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      cmp++; if (overrun !== 1'b0) begin errs++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
      rst = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (done || busy || tx_valid) bad++;
      end
      cmp++; if (bad !== 0) begin errs++; $display("FAIL mid_no_done: got %0d active cycles want 0", bad); end
      ch_data = {32'h00000001, 32'h77777777, 32'hDEADBEEF, 32'h12345678};
      ch_mask = 4'b1010;
      pulse_snap();
      run_frame(30, 16'hFFFF, 0, 1'b0, 32'h0);
      cmp++; if (got.size() !== exp.size()) begin errs++; $display("FAIL mid_len: got %0d want %0d", got.size(), exp.size()); end
      for (int i = 0; i < exp.size(); i++) begin
         cmp++; if (i >= got.size() || got[i] !== exp[i]) begin errs++; $display("FAIL mid_byte%0d: got %h want %h", i, i < got.size() ? got[i] : 8'h00, exp[i]); end
      end
      cmp++; if (done_c !== exp.size() + 1) begin errs++; $display("FAIL mid_done_cycle: got %0d want %0d", done_c, exp.size() + 1); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_skip();
      test_empty();
      test_stall();
      test_overrun();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
      $finish;
   end
endmodule
